// File: rtl/ram_burst_ctrl.sv
// Burst controller owning the port of a 16x8 single-port synchronous RAM.
// Define RAM_BURST_CTRL_STATS_EN to add saturating write/read beat counters.
module ram_burst_ctrl #(
  parameter int unsigned ADDR_W = 4,
  parameter int unsigned DATA_W = 8,
  parameter int unsigned LEN_W  = 4
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_cmd_valid,
  output logic              o_cmd_ready,
  input  logic              i_cmd_write,
  input  logic [ADDR_W-1:0] i_cmd_addr,
  input  logic [LEN_W-1:0]  i_cmd_len,
  input  logic              i_wr_valid,
  output logic              o_wr_ready,
  input  logic [DATA_W-1:0] i_wr_data,
  output logic              o_rd_valid,
  input  logic              i_rd_ready,
  output logic [DATA_W-1:0] o_rd_data,
  output logic              o_rd_last,
  output logic              o_ram_we,
  output logic [ADDR_W-1:0] o_ram_addr,
  output logic [DATA_W-1:0] o_ram_wdata,
  input  logic [DATA_W-1:0] i_ram_rdata,
  output logic              o_busy
`ifdef RAM_BURST_CTRL_STATS_EN
  ,
  output logic [15:0]       o_stat_wr_beats,
  output logic [15:0]       o_stat_rd_beats
`endif
);

  typedef enum logic [1:0] {StIdle, StWrite, StRead, StDrain} state_e;

  state_e r_state, w_state_next;

  logic [ADDR_W-1:0] r_addr;
  logic [LEN_W-1:0]  r_len;
  logic [LEN_W-1:0]  r_cnt;

  logic              r_ram_we;
  logic [ADDR_W-1:0] r_ram_addr;
  logic [DATA_W-1:0] r_ram_wdata;

  // Read pipeline: p1 = address on RAM pins, p2 = RAM data valid.
  logic r_p1_vld, r_p1_last, r_p2_vld, r_p2_last;

  logic [DATA_W-1:0] r_fifo_data [4];
  logic [3:0]        r_fifo_last;
  logic [1:0]        r_wptr, r_rptr;
  logic [2:0]        r_count;

  logic       w_cmd_hs, w_wr_hs, w_issue, w_push, w_pop, w_cnt_done;
  logic [2:0] w_credit;

  assign o_cmd_ready = (r_state == StIdle);
  assign o_wr_ready  = (r_state == StWrite);
  assign o_busy      = (r_state != StIdle);

  assign w_cmd_hs   = i_cmd_valid & o_cmd_ready;
  assign w_wr_hs    = i_wr_valid & o_wr_ready;
  assign w_cnt_done = (r_cnt == r_len);

  // Credits reserve a FIFO slot for every read still travelling through the RAM.
  assign w_credit = r_count + {2'b00, r_p1_vld} + {2'b00, r_p2_vld};
  assign w_issue  = (r_state == StRead) && (w_credit < 3'd4);
  assign w_push   = r_p2_vld;

  assign o_rd_valid = (r_count != 3'd0);
  assign w_pop      = o_rd_valid & i_rd_ready;
  assign o_rd_data  = r_fifo_data[r_rptr];
  assign o_rd_last  = o_rd_valid & r_fifo_last[r_rptr];

  assign o_ram_we    = r_ram_we;
  assign o_ram_addr  = r_ram_addr;
  assign o_ram_wdata = r_ram_wdata;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      StIdle: begin
        if (w_cmd_hs) begin
          w_state_next = i_cmd_write ? StWrite : StRead;
        end
      end
      StWrite: begin
        if (w_wr_hs && w_cnt_done) begin
          w_state_next = StIdle;
        end
      end
      StRead: begin
        if (w_issue && w_cnt_done) begin
          w_state_next = StDrain;
        end
      end
      StDrain: begin
        if (w_pop && o_rd_last) begin
          w_state_next = StIdle;
        end
      end
      default: w_state_next = StIdle;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_addr <= '0;
      r_len  <= '0;
      r_cnt  <= '0;
    end else if (w_cmd_hs) begin
      r_addr <= i_cmd_addr;
      r_len  <= i_cmd_len;
      r_cnt  <= '0;
    end else if (w_wr_hs || w_issue) begin
      r_addr <= r_addr + ADDR_W'(1);
      r_cnt  <= r_cnt + LEN_W'(1);
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_ram_we    <= 1'b0;
      r_ram_addr  <= '0;
      r_ram_wdata <= '0;
    end else begin
      r_ram_we <= w_wr_hs;
      if (w_wr_hs) begin
        r_ram_addr  <= r_addr;
        r_ram_wdata <= i_wr_data;
      end else if (w_issue) begin
        r_ram_addr <= r_addr;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_p1_vld  <= 1'b0;
      r_p1_last <= 1'b0;
      r_p2_vld  <= 1'b0;
      r_p2_last <= 1'b0;
    end else begin
      r_p1_vld  <= w_issue;
      r_p1_last <= w_issue & w_cnt_done;
      r_p2_vld  <= r_p1_vld;
      r_p2_last <= r_p1_last;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      for (int i = 0; i < 4; i++) begin
        r_fifo_data[i] <= '0;
      end
      r_fifo_last <= '0;
      r_wptr      <= '0;
      r_rptr      <= '0;
      r_count     <= '0;
    end else begin
      if (w_push) begin
        r_fifo_data[r_wptr] <= i_ram_rdata;
        r_fifo_last[r_wptr] <= r_p2_last;
        r_wptr              <= r_wptr + 2'd1;
      end
      if (w_pop) begin
        r_rptr <= r_rptr + 2'd1;
      end
      r_count <= r_count + {2'b00, w_push} - {2'b00, w_pop};
    end
  end

`ifdef RAM_BURST_CTRL_STATS_EN
  logic [15:0] r_stat_wr, r_stat_rd;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_stat_wr <= '0;
      r_stat_rd <= '0;
    end else begin
      if (w_wr_hs && (r_stat_wr != 16'hFFFF)) begin
        r_stat_wr <= r_stat_wr + 16'd1;
      end
      if (w_pop && (r_stat_rd != 16'hFFFF)) begin
        r_stat_rd <= r_stat_rd + 16'd1;
      end
    end
  end

  assign o_stat_wr_beats = r_stat_wr;
  assign o_stat_rd_beats = r_stat_rd;
`endif

endmodule

// File: tb/tb_ram_burst_ctrl.sv
// Self-checking bench for ram_burst_ctrl: RAM model, shadow-memory scoreboard
// and directed burst scenarios with literal expectations.
module tb_ram_burst_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       cmd_valid, cmd_ready, cmd_write;
  logic [3:0] cmd_addr, cmd_len;
  logic       wr_valid, wr_ready;
  logic [7:0] wr_data;
  logic       rd_valid, rd_ready, rd_last;
  logic [7:0] rd_data;
  logic       ram_we;
  logic [3:0] ram_addr;
  logic [7:0] ram_wdata, ram_rdata;
  logic       busy;
`ifdef RAM_BURST_CTRL_STATS_EN
  logic [15:0] stat_wr_beats, stat_rd_beats;
`endif

  always #5 clk = ~clk;

  ram_burst_ctrl dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_cmd_valid (cmd_valid),
    .o_cmd_ready (cmd_ready),
    .i_cmd_write (cmd_write),
    .i_cmd_addr  (cmd_addr),
    .i_cmd_len   (cmd_len),
    .i_wr_valid  (wr_valid),
    .o_wr_ready  (wr_ready),
    .i_wr_data   (wr_data),
    .o_rd_valid  (rd_valid),
    .i_rd_ready  (rd_ready),
    .o_rd_data   (rd_data),
    .o_rd_last   (rd_last),
    .o_ram_we    (ram_we),
    .o_ram_addr  (ram_addr),
    .o_ram_wdata (ram_wdata),
    .i_ram_rdata (ram_rdata),
    .o_busy      (busy)
`ifdef RAM_BURST_CTRL_STATS_EN
    ,
    .o_stat_wr_beats (stat_wr_beats),
    .o_stat_rd_beats (stat_rd_beats)
`endif
  );

  // Single-port synchronous RAM with one-cycle registered read.
  logic [7:0] ram [16];
  always @(posedge clk) begin
    if (ram_we) ram[ram_addr] <= ram_wdata;
    ram_rdata <= ram[ram_addr];
  end

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0]  shadow [16];
  logic [11:0] exp_wr [$];
  logic [8:0]  exp_rd [$];
  logic [8:0]  got_rd [$];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  // RAM-port write monitor against the expected write list.
  always @(negedge clk) begin
    logic [11:0] e;
    if (ram_we) begin
      if (exp_wr.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected ram write: addr %0h data %0h, expected none", ram_addr, ram_wdata);
      end else begin
        e = exp_wr.pop_front();
        check("ram write addr", {28'd0, ram_addr}, {28'd0, e[11:8]});
        check("ram write data", {24'd0, ram_wdata}, {24'd0, e[7:0]});
      end
    end
  end

  // Read-beat scoreboard: every handshake must match the next expected beat.
  always @(negedge clk) begin
    logic [8:0] e;
    if (rst_n && rd_valid && rd_ready) begin
      if (exp_rd.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected rd beat: got data %0h, expected no beat", rd_data);
      end else begin
        e = exp_rd.pop_front();
        check("rd_data", {24'd0, rd_data}, {24'd0, e[7:0]});
        check("rd_last", {31'd0, rd_last}, {31'd0, e[8]});
      end
      got_rd.push_back({rd_last, rd_data});
    end
  end

  // Head must stay put while stalled.
  logic       prev_stall = 1'b0;
  logic [8:0] prev_head;
  always @(negedge clk) begin
    if (prev_stall && rst_n) begin
      check("stall rd_valid", {31'd0, rd_valid}, 32'd1);
      check("stall head", {23'd0, rd_last, rd_data}, {23'd0, prev_head});
    end
    prev_stall = rst_n && rd_valid && !rd_ready;
    prev_head  = {rd_last, rd_data};
  end

  task automatic wait_cmd_ready();
    int k = 0;
    @(negedge clk);
    while (!cmd_ready && k < 50) begin
      @(negedge clk);
      k++;
    end
    check("cmd_ready wait", {31'd0, cmd_ready}, 32'd1);
  endtask

  task automatic wr_burst(input logic [3:0] a, input logic [3:0] len, input logic [7:0] base);
    logic [3:0] ad;
    logic [7:0] d;
    for (int i = 0; i <= int'(len); i++) begin
      ad = a + 4'(i);
      d  = base + 8'(i);
      shadow[ad] = d;
      exp_wr.push_back({ad, d});
    end
    cmd_valid = 1'b1;
    cmd_write = 1'b1;
    cmd_addr  = a;
    cmd_len   = len;
    wait_cmd_ready();
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    wr_valid  = 1'b1;
    wr_data   = base;
    for (int i = 0; i <= int'(len); i++) begin
      @(negedge clk);
      check("wr_ready", {31'd0, wr_ready}, 32'd1);
      check("ram_we beat", {31'd0, ram_we}, (i > 0) ? 32'd1 : 32'd0);
      if (i > 0) check("ram_addr beat", {28'd0, ram_addr}, {28'd0, a + 4'(i - 1)});
      @(posedge clk);
      #1;
      wr_data = base + 8'(i + 1);
      if (i == int'(len)) wr_valid = 1'b0;
    end
    @(negedge clk);
    check("last ram_we", {31'd0, ram_we}, 32'd1);
    check("last ram_addr", {28'd0, ram_addr}, {28'd0, a + len});
    check("cmd_ready after write", {31'd0, cmd_ready}, 32'd1);
    check("busy after write", {31'd0, busy}, 32'd0);
    @(posedge clk);
    #1;
    @(negedge clk);
    check("ram_we idle", {31'd0, ram_we}, 32'd0);
    @(posedge clk);
    #1;
  endtask

  task automatic start_read(input logic [3:0] a, input logic [3:0] len);
    logic [3:0] ad;
    for (int i = 0; i <= int'(len); i++) begin
      ad = a + 4'(i);
      exp_rd.push_back({(i == int'(len)), shadow[ad]});
    end
    got_rd.delete();
    cmd_valid = 1'b1;
    cmd_write = 1'b0;
    cmd_addr  = a;
    cmd_len   = len;
    wait_cmd_ready();
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
  endtask

  task automatic wait_read_done();
    int k = 0;
    while ((exp_rd.size() != 0 || busy) && k < 300) begin
      @(posedge clk);
      #1;
      k++;
    end
    check("read drain", {31'd0, (exp_rd.size() == 0) && !busy}, 32'd1);
  endtask

  task automatic check_got(input int idx, input logic [8:0] exp);
    if (got_rd.size() > idx) check("beat literal", {23'd0, got_rd[idx]}, {23'd0, exp});
    else check("beat present", 32'(got_rd.size()), 32'(idx + 1));
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    rst_n     = 1'b0;
    cmd_valid = 1'b0;
    cmd_write = 1'b0;
    cmd_addr  = '0;
    cmd_len   = '0;
    wr_valid  = 1'b0;
    wr_data   = '0;
    rd_ready  = 1'b1;
    for (int i = 0; i < 16; i++) shadow[i] = 8'h00;

    // Reset values
    @(posedge clk);
    @(negedge clk);
    check("rst cmd_ready", {31'd0, cmd_ready}, 32'd1);
    check("rst busy", {31'd0, busy}, 32'd0);
    check("rst wr_ready", {31'd0, wr_ready}, 32'd0);
    check("rst rd_valid", {31'd0, rd_valid}, 32'd0);
    check("rst rd_last", {31'd0, rd_last}, 32'd0);
    check("rst rd_data", {24'd0, rd_data}, 32'd0);
    check("rst ram_we", {31'd0, ram_we}, 32'd0);
    check("rst ram_addr", {28'd0, ram_addr}, 32'd0);
    check("rst ram_wdata", {24'd0, ram_wdata}, 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Write A0..A3 at 2, then read back with cycle-exact timing
    wr_burst(4'd2, 4'd3, 8'hA0);
    start_read(4'd2, 4'd3);
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      check("rd_valid timing", {31'd0, rd_valid}, (k >= 4 && k <= 7) ? 32'd1 : 32'd0);
      if (k >= 4 && k <= 7) check("rd_last timing", {31'd0, rd_last}, (k == 7) ? 32'd1 : 32'd0);
    end
    @(posedge clk);
    #1;
    wait_read_done();
    check_got(0, 9'h0A0);
    check_got(1, 9'h0A1);
    check_got(2, 9'h0A2);
    check_got(3, 9'h1A3);
`ifdef RAM_BURST_CTRL_STATS_EN
    check("stat_wr_beats", {16'd0, stat_wr_beats}, 32'd4);
    check("stat_rd_beats", {16'd0, stat_rd_beats}, 32'd4);
`endif

    // Address wrap 14,15,0,1
    wr_burst(4'd14, 4'd3, 8'h01);
    start_read(4'd14, 4'd3);
    wait_read_done();
    check_got(0, 9'h001);
    check_got(3, 9'h104);

    // 16-beat read with 10 stalled cycles: issue must stop after four credits
    wr_burst(4'd5, 4'd15, 8'h10);
    rd_ready = 1'b0;
    start_read(4'd5, 4'd15);
    repeat (10) @(negedge clk);
    check("stall ram_addr", {28'd0, ram_addr}, 32'd8);
    check("stall rd_valid", {31'd0, rd_valid}, 32'd1);
    check("stall busy", {31'd0, busy}, 32'd1);
    @(posedge clk);
    #1;
    rd_ready = 1'b1;
    wait_read_done();
    check("stall beat count", 32'(got_rd.size()), 32'd16);
    check_got(0, 9'h010);
    check_got(15, 9'h11F);

    // Reset in the middle of a read burst
    start_read(4'd0, 4'd15);
    repeat (6) @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    exp_rd.delete();
    @(negedge clk);
    check("mid-rst rd_valid", {31'd0, rd_valid}, 32'd0);
    check("mid-rst busy", {31'd0, busy}, 32'd0);
    check("mid-rst cmd_ready", {31'd0, cmd_ready}, 32'd1);
    check("mid-rst rd_last", {31'd0, rd_last}, 32'd0);
    check("mid-rst ram_addr", {28'd0, ram_addr}, 32'd0);
    @(posedge clk);
    #1;
    start_read(4'd2, 4'd3);
    wait_read_done();
    check("post-rst beat count", 32'(got_rd.size()), 32'd4);
    check_got(0, 9'h01D);
    check_got(3, 9'h110);
    check("write list drained", 32'(exp_wr.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
